// File: rtl/ss_reg_sequencer.sv
// Savestate register-bus master: walks every SaveStateBus index to save it to memory,
// restore it from memory, or pulses the bus-wide defaults strobe.
module ss_reg_sequencer #(
    parameter int          NUM_REGS = 64,
    parameter logic [25:0] MEM_BASE = 26'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        save_start,
    input  logic        load_start,
    input  logic        dflt_start,
    output logic        busy,
    output logic        done,
    output logic [9:0]  SaveStateBus_Adr,
    output logic [63:0] SaveStateBus_Din,
    output logic        SaveStateBus_wren,
    output logic        SaveStateBus_rst,
    input  logic [63:0] SaveStateBus_Dout,
    output logic [25:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam logic [9:0] LAST = 10'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE, S_ADR, S_CAP, S_WR, L_RD, L_WR, D_RST, FIN
    } state_t;

    state_t      state, state_nx;
    logic [9:0]  idx, idx_nx;
    logic [9:0]  adr_q;
    logic [63:0] din_q;
    logic [63:0] wdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            adr_q   <= '0;
            din_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            // Adr is set on entry so it is already stable in the S_ADR / L_WR cycle
            if (state_nx == S_ADR || state_nx == L_WR)
                adr_q <= idx_nx;
            if (state == S_CAP)
                wdata_q <= SaveStateBus_Dout;
            if (state == L_RD && mem_ack)
                din_q <= mem_rdata;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (save_start) begin
                    state_nx = S_ADR;
                    idx_nx   = '0;
                end else if (load_start) begin
                    state_nx = L_RD;
                    idx_nx   = '0;
                end else if (dflt_start) begin
                    state_nx = D_RST;
                    idx_nx   = '0;
                end
            end
            S_ADR: state_nx = S_CAP;
            S_CAP: state_nx = S_WR;
            S_WR: begin
                if (mem_ack) begin
                    if (idx == LAST) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = S_ADR;
                        idx_nx   = idx + 10'd1;
                    end
                end
            end
            L_RD: if (mem_ack) state_nx = L_WR;
            L_WR: begin
                if (idx == LAST) begin
                    state_nx = FIN;
                end else begin
                    state_nx = L_RD;
                    idx_nx   = idx + 10'd1;
                end
            end
            D_RST:   state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy              = (state != IDLE);
    assign done              = (state == FIN);
    assign mem_wr            = (state == S_WR);
    assign mem_rd            = (state == L_RD);
    assign SaveStateBus_wren = (state == L_WR);
    assign SaveStateBus_rst  = (state == D_RST);
    assign SaveStateBus_Adr  = adr_q;
    assign SaveStateBus_Din  = din_q;
    assign mem_wdata         = wdata_q;
    // Address is only meaningful while a request is up; 26-bit wrap is intended
    assign mem_addr          = (mem_wr || mem_rd) ? (MEM_BASE + {16'b0, idx}) : 26'h0;

endmodule

// File: tb/tb_ss_reg_sequencer.sv
// Directed bench for ss_reg_sequencer: table of whole sequences plus hand-written
// corner cases (mid-sequence reset, 1024-entry address wrap).
module tb_ss_reg_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        save_start, load_start, dflt_start;
    logic        busy, done;
    logic [9:0]  adr;
    logic [63:0] din, dout;
    logic        wren, brst;
    logic [25:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic        mem_wr, mem_rd, mem_ack;

    logic        save_b;
    logic        busy_b, done_b, wren_b, brst_b, mem_wr_b, mem_rd_b, mem_ack_b;
    logic [9:0]  adr_b;
    logic [63:0] din_b, mem_wdata_b;
    logic [25:0] mem_addr_b;

    always #5 clk = ~clk;

    ss_reg_sequencer #(.NUM_REGS(4), .MEM_BASE(26'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .save_start(save_start), .load_start(load_start), .dflt_start(dflt_start),
        .busy(busy), .done(done),
        .SaveStateBus_Adr(adr), .SaveStateBus_Din(din),
        .SaveStateBus_wren(wren), .SaveStateBus_rst(brst),
        .SaveStateBus_Dout(dout),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    ss_reg_sequencer #(.NUM_REGS(1024), .MEM_BASE(26'h3FFFFFF)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .save_start(save_b), .load_start(1'b0), .dflt_start(1'b0),
        .busy(busy_b), .done(done_b),
        .SaveStateBus_Adr(adr_b), .SaveStateBus_Din(din_b),
        .SaveStateBus_wren(wren_b), .SaveStateBus_rst(brst_b),
        .SaveStateBus_Dout(64'h0),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_wr(mem_wr_b), .mem_rd(mem_rd_b), .mem_ack(mem_ack_b), .mem_rdata(64'h0)
    );

    // Slave model: registered read data, one cycle behind Adr
    always @(posedge clk) dout <= 64'hA0 + {54'b0, adr};

    // Memory model: ack after mem_lat wait cycles (0 = same cycle), word i holds 1111*i
    int mem_lat = 0;
    int wait_cnt = 0;
    assign mem_ack   = (mem_wr || mem_rd) && (wait_cnt == mem_lat);
    assign mem_rdata = 64'h1111 * {38'b0, mem_addr};
    always @(posedge clk) wait_cnt <= ((mem_wr || mem_rd) && !mem_ack) ? wait_cnt + 1 : 0;
    assign mem_ack_b = mem_wr_b || mem_rd_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors sample on the falling edge
    logic [25:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    logic [9:0]  wren_adr_q[$];
    logic [63:0] wren_din_q[$];
    int rst_cnt, done_cnt, done_cyc, both_cnt;
    logic [25:0] b_addr_q[$];
    int b_done_cnt;

    always @(negedge clk) begin
        if (mem_wr && mem_ack) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (wren) begin
            wren_adr_q.push_back(adr);
            wren_din_q.push_back(din);
        end
        if (brst) rst_cnt = rst_cnt + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (mem_wr && mem_rd) both_cnt = both_cnt + 1;
        if (mem_wr_b && mem_ack_b) b_addr_q.push_back(mem_addr_b);
        if (done_b) b_done_cnt = b_done_cnt + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wren_adr_q.delete();
        wren_din_q.delete();
        rst_cnt  = 0;
        done_cnt = 0;
        done_cyc = -1;
        both_cnt = 0;
    endtask

    typedef struct {
        logic sv, ld, df;
        logic poke;       // pulse load_start again while busy
        int   lat;
        int   exp_done;   // cycles from start pulse to done
        int   exp_wr;
        int   exp_wren;
        int   exp_rst;
    } vec_t;

    vec_t tbl[7];

    task automatic run_vec(input vec_t v, input int n);
        int start_cyc;
        bit got;
        clear_logs();
        mem_lat    = v.lat;
        start_cyc  = cyc;
        save_start = v.sv;
        load_start = v.ld;
        dflt_start = v.df;
        step();
        save_start = 1'b0;
        load_start = 1'b0;
        dflt_start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done_cnt > 0) begin
                got = 1'b1;
                break;
            end
            load_start = (v.poke && k == 2);
            step();
        end
        load_start = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL v%0d_timeout actual=no_done expected=done", n);
        end
        chk($sformatf("v%0d_busy_after", n), {63'b0, busy}, 64'd0);
        chk($sformatf("v%0d_done_cycle", n), done_cyc - start_cyc, v.exp_done);
        step();
        step();
        chk($sformatf("v%0d_done_pulses", n), done_cnt, 1);
        chk($sformatf("v%0d_mem_wr_count", n), wr_addr_q.size(), v.exp_wr);
        chk($sformatf("v%0d_wren_count", n), wren_adr_q.size(), v.exp_wren);
        chk($sformatf("v%0d_rst_count", n), rst_cnt, v.exp_rst);
        chk($sformatf("v%0d_wr_rd_overlap", n), both_cnt, 0);
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            chk($sformatf("v%0d_wr_addr%0d", n, i), wr_addr_q[i], i);
            chk($sformatf("v%0d_wr_data%0d", n, i), wr_data_q[i], 64'hA0 + i);
        end
        for (int i = 0; i < wren_adr_q.size(); i++) begin
            chk($sformatf("v%0d_wren_adr%0d", n, i), wren_adr_q[i], i);
            chk($sformatf("v%0d_wren_din%0d", n, i), wren_din_q[i], 64'h1111 * i);
        end
    endtask

    initial begin
        bit hit;
        //           sv    ld    df    poke  lat done wr wren rst
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 13, 4, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 21, 0, 4, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 0,  2, 0, 0, 1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 13, 4, 0, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 21, 4, 0, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  9, 0, 4, 0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 13, 0, 4, 0};

        reset_n    = 1'b0;
        save_start = 1'b0;
        load_start = 1'b0;
        dflt_start = 1'b0;
        save_b     = 1'b0;
        b_done_cnt = 0;
        clear_logs();
        step();
        step();
        chk("reset_ctrl", {busy, done, mem_wr, mem_rd, wren, brst}, 64'd0);
        chk("reset_adr_din", {54'b0, adr} | din, 64'd0);
        chk("reset_mem", {38'b0, mem_addr} | mem_wdata, 64'd0);
        reset_n = 1'b1;
        step();
        chk("idle_busy", {63'b0, busy}, 64'd0);

        for (int n = 0; n < 7; n++) run_vec(tbl[n], n);

        // Reset in the middle of a save, while index 2 is waiting on memory
        clear_logs();
        mem_lat    = 5;
        save_start = 1'b1;
        step();
        save_start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (mem_wr && mem_addr == 26'd2) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("midrst_reached_idx2", {63'b0, hit}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_outputs", {busy, done, mem_wr}, 64'd0);
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        chk("midrst_idle", {busy, done, mem_wr, mem_rd, wren}, 64'd0);
        chk("midrst_no_done", done_cnt, 0);
        run_vec(tbl[2], 7);

        // 1024 entries from a base at the top of the address space
        b_addr_q.delete();
        b_done_cnt = 0;
        save_b = 1'b1;
        step();
        save_b = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (done_b) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("wrap_done", {63'b0, hit}, 64'd1);
        chk("wrap_last_adr", adr_b, 10'h3FF);
        chk("wrap_count", b_addr_q.size(), 1024);
        if (b_addr_q.size() == 1024) begin
            chk("wrap_addr0", b_addr_q[0], 26'h3FFFFFF);
            chk("wrap_addr1", b_addr_q[1], 26'h0);
            chk("wrap_addr_last", b_addr_q[1023], 26'h3FE);
        end
        step();
        step();
        chk("wrap_done_pulses", b_done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
